// File: rtl/sprite_pos_pkg.sv
// Shared constants, state encoding and helpers for the sprite position controller.
package sprite_pos_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;
  localparam int H_PIC_DEF   = 100;
  localparam int W_PIC_DEF   = 100;

  localparam int X_MAX_DEF = H_VALID_DEF - H_PIC_DEF;
  localparam int Y_MAX_DEF = V_VALID_DEF - W_PIC_DEF;

  // Bit positions inside cmd_dir = {up, down, left, right}
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  // A zero step would make a command a no-op, so it is promoted to one pixel
  function automatic logic [3:0] eff_step(input logic [3:0] step);
    return (step == 4'd0) ? 4'd1 : step;
  endfunction

endpackage

// File: rtl/sprite_pos_ctrl_sat_step.sv
// One axis of saturating movement: value +/- step, clamped to [0, limit].
// Arithmetic is done wide and signed so neither end can wrap around.
module sat_step (
  input  logic [9:0] value,
  input  logic [3:0] step,
  input  logic       dir,
  input  logic [9:0] limit,
  output logic [9:0] next_value,
  output logic       hit_limit
);

  logic signed [11:0] sum;

  // Compute the moved value and clamp it, flagging when a bound was reached
  always_comb begin
    sum        = '0;
    next_value = value;
    hit_limit  = 1'b0;
    if (dir) begin
      sum = $signed({2'b00, value}) + $signed({8'd0, step});
      if (sum >= $signed({2'b00, limit})) begin
        next_value = limit;
        hit_limit  = 1'b1;
      end else begin
        next_value = sum[9:0];
      end
    end else begin
      sum = $signed({2'b00, value}) - $signed({8'd0, step});
      if (sum <= 12'sd0) begin
        next_value = '0;
        hit_limit  = 1'b1;
      end else begin
        next_value = sum[9:0];
      end
    end
  end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: manual moves from a one-entry command slot, or
// autonomous bouncing, with all position updates confined to the frame tick.
module sprite_pos_ctrl
  import sprite_pos_pkg::*;
#(
  parameter int H_VALID = H_VALID_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter int H_PIC   = H_PIC_DEF,
  parameter int W_PIC   = W_PIC_DEF
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_dir,
  input  logic [3:0]  cmd_step,
  input  logic        mode_auto,
  output logic [9:0]  x_move,
  output logic [9:0]  y_move,
  output logic        frame_tick
);

  localparam logic [9:0] X_MAX = 10'(H_VALID - H_PIC);
  localparam logic [9:0] Y_MAX = 10'(V_VALID - W_PIC);

  state_t     state;
  state_t     next_state;
  logic       frame_end;
  logic       cmd_accept;
  logic       slot_full;
  logic [3:0] slot_dir;
  logic [3:0] slot_step;
  logic [3:0] auto_step;
  logic       x_dir;
  logic       y_dir;
  logic       x_en;
  logic       y_en;
  logic       x_inc;
  logic       y_inc;
  logic [3:0] x_step;
  logic [3:0] y_step;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       x_hit;
  logic       y_hit;

  assign frame_end  = (pix_x == 12'(H_VALID - 1)) && (pix_y == 12'(V_VALID - 1));
  assign cmd_ready  = (state == ST_AUTO) || !slot_full;
  assign cmd_accept = cmd_valid && cmd_ready;

  // Register the frame-end condition into a one-cycle tick
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
    end
  end

  // Mode state register
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_MANUAL;
    end else begin
      state <= next_state;
    end
  end

  // Mode changes only at frame tick, following the mode_auto level
  always_comb begin
    next_state = state;
    if (frame_tick) begin
      case (state)
        ST_MANUAL: if (mode_auto)  next_state = ST_AUTO;
        ST_AUTO:   if (!mode_auto) next_state = ST_MANUAL;
        default:   next_state = ST_MANUAL;
      endcase
    end
  end

  // Pick per-axis step/direction for the mode being entered on this tick
  always_comb begin
    x_en   = 1'b0;
    y_en   = 1'b0;
    x_inc  = 1'b0;
    y_inc  = 1'b0;
    x_step = 4'd1;
    y_step = 4'd1;
    if (next_state == ST_AUTO) begin
      x_en   = 1'b1;
      y_en   = 1'b1;
      x_inc  = x_dir;
      y_inc  = y_dir;
      x_step = auto_step;
      y_step = auto_step;
    end else if (slot_full) begin
      x_en   = slot_dir[DIR_LEFT] ^ slot_dir[DIR_RIGHT];
      x_inc  = slot_dir[DIR_RIGHT];
      y_en   = slot_dir[DIR_UP] ^ slot_dir[DIR_DOWN];
      y_inc  = slot_dir[DIR_DOWN];
      x_step = eff_step(slot_step);
      y_step = eff_step(slot_step);
    end
  end

  sat_step u_sat_x (
    .value      (x_move),
    .step       (x_step),
    .dir        (x_inc),
    .limit      (X_MAX),
    .next_value (x_next),
    .hit_limit  (x_hit)
  );

  sat_step u_sat_y (
    .value      (y_move),
    .step       (y_step),
    .dir        (y_inc),
    .limit      (Y_MAX),
    .next_value (y_next),
    .hit_limit  (y_hit)
  );

  // Position only updates on the frame tick so it is stable over the active area
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_move <= '0;
      y_move <= '0;
    end else if (frame_tick) begin
      if (x_en) x_move <= x_next;
      if (y_en) y_move <= y_next;
    end
  end

  // Bounce flags flip whenever an autonomous move lands on a bound
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_dir <= 1'b1;
      y_dir <= 1'b1;
    end else if (frame_tick && (next_state == ST_AUTO)) begin
      if (x_hit) x_dir <= ~x_dir;
      if (y_hit) y_dir <= ~y_dir;
    end
  end

  // In autonomous mode a command only retunes the bounce speed
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      auto_step <= 4'd1;
    end else if (cmd_accept && (state == ST_AUTO)) begin
      auto_step <= eff_step(cmd_step);
    end
  end

  // Single command slot: filled on manual accept, drained on every tick,
  // and wiped whenever the mode changes
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_full <= 1'b0;
      slot_dir  <= '0;
      slot_step <= '0;
    end else if (frame_tick && (next_state != state)) begin
      slot_full <= 1'b0;
    end else if (cmd_accept && (state == ST_MANUAL)) begin
      slot_full <= 1'b1;
      slot_dir  <= cmd_dir;
      slot_step <= cmd_step;
    end else if (frame_tick) begin
      slot_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Directed bench for sprite_pos_ctrl; pixel coordinates are driven directly.
module tb_sprite_pos_ctrl;

  logic        vga_clk;
  logic        sys_rst_n;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dir;
  logic [3:0]  cmd_step;
  logic        mode_auto;
  logic [9:0]  x_move;
  logic [9:0]  y_move;
  logic        frame_tick;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [3:0] D_RIGHT = 4'b0001;
  localparam logic [3:0] D_LEFT  = 4'b0010;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_UP    = 4'b1000;

  sprite_pos_ctrl dut (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_step   (cmd_step),
    .mode_auto  (mode_auto),
    .x_move     (x_move),
    .y_move     (y_move),
    .frame_tick (frame_tick)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic sendCmd(input logic [3:0] dir, input logic [3:0] step);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_step  = step;
    stepClk();
    cmd_valid = 1'b0;
  endtask

  task automatic runFrameEnd();
    pix_x = 12'd639;
    pix_y = 12'd479;
    stepClk();
    pix_x = 12'd100;
    pix_y = 12'd50;
    stepClk();
  endtask

  task automatic applyStimulus(input logic [3:0] dir, input logic [3:0] step);
    sendCmd(dir, step);
    runFrameEnd();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    pix_x     = 12'd100;
    pix_y     = 12'd50;
    cmd_valid = 1'b0;
    cmd_dir   = '0;
    cmd_step  = '0;
    mode_auto = 1'b0;
    #55;
    sys_rst_n = 1'b1;
    stepClk();

    checkOutput("rst_x", 32'(x_move), 0);
    checkOutput("rst_y", 32'(y_move), 0);
    checkOutput("rst_tick", 32'(frame_tick), 0);
    checkOutput("rst_ready", 32'(cmd_ready), 1);

    pix_x = 12'd639;
    pix_y = 12'd0;
    stepClk();
    pix_x = 12'd100;
    pix_y = 12'd50;
    checkOutput("no_tick_line_end", 32'(frame_tick), 0);

    sendCmd(D_RIGHT, 4'd5);
    checkOutput("r5_ready_low", 32'(cmd_ready), 0);
    checkOutput("r5_x_pending", 32'(x_move), 0);
    pix_x = 12'd639;
    pix_y = 12'd479;
    stepClk();
    checkOutput("tick_high", 32'(frame_tick), 1);
    checkOutput("r5_x_on_tick", 32'(x_move), 0);
    pix_x = 12'd100;
    pix_y = 12'd50;
    stepClk();
    checkOutput("r5_x_applied", 32'(x_move), 5);
    checkOutput("tick_one_cycle", 32'(frame_tick), 0);
    checkOutput("r5_ready_back", 32'(cmd_ready), 1);

    for (int i = 0; i < 35; i++) applyStimulus(D_RIGHT, 4'd15);
    checkOutput("x_530", 32'(x_move), 530);
    applyStimulus(D_RIGHT, 4'd8);
    checkOutput("x_538", 32'(x_move), 538);
    applyStimulus(D_RIGHT, 4'd8);
    checkOutput("x_sat_max", 32'(x_move), 540);
    applyStimulus(D_LEFT, 4'd0);
    checkOutput("x_step0_left", 32'(x_move), 539);

    applyStimulus(D_LEFT | D_RIGHT | D_DOWN, 4'd3);
    checkOutput("opp_x_hold", 32'(x_move), 539);
    checkOutput("opp_y_add", 32'(y_move), 3);
    applyStimulus(D_UP, 4'd15);
    checkOutput("y_sat_zero", 32'(y_move), 0);

    sendCmd(D_LEFT, 4'd2);
    checkOutput("slot_full_ready", 32'(cmd_ready), 0);
    sendCmd(D_RIGHT, 4'd9);
    runFrameEnd();
    checkOutput("second_cmd_dropped", 32'(x_move), 537);
    checkOutput("ready_after_drain", 32'(cmd_ready), 1);

    pix_x = 12'd639;
    pix_y = 12'd479;
    stepClk();
    checkOutput("tick_for_late_cmd", 32'(frame_tick), 1);
    checkOutput("ready_on_tick", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_dir   = D_LEFT;
    cmd_step  = 4'd4;
    pix_x = 12'd100;
    pix_y = 12'd50;
    stepClk();
    cmd_valid = 1'b0;
    checkOutput("late_cmd_not_yet", 32'(x_move), 537);
    checkOutput("late_cmd_held", 32'(cmd_ready), 0);
    runFrameEnd();
    checkOutput("late_cmd_applied", 32'(x_move), 533);

    applyStimulus(D_RIGHT, 4'd6);
    checkOutput("x_539_pre_auto", 32'(x_move), 539);

    mode_auto = 1'b1;
    runFrameEnd();
    checkOutput("auto_x_hit", 32'(x_move), 540);
    checkOutput("auto_y_1", 32'(y_move), 1);
    runFrameEnd();
    checkOutput("auto_x_bounce", 32'(x_move), 539);
    checkOutput("auto_y_2", 32'(y_move), 2);
    checkOutput("auto_ready", 32'(cmd_ready), 1);
    applyStimulus(4'b1111, 4'd15);
    checkOutput("auto_step_x", 32'(x_move), 524);
    checkOutput("auto_step_y", 32'(y_move), 17);
    for (int i = 0; i < 24; i++) runFrameEnd();
    checkOutput("auto_y_377", 32'(y_move), 377);
    checkOutput("auto_x_164", 32'(x_move), 164);
    runFrameEnd();
    checkOutput("auto_y_hit", 32'(y_move), 380);
    checkOutput("auto_x_149", 32'(x_move), 149);
    runFrameEnd();
    checkOutput("auto_y_reflect", 32'(y_move), 365);
    checkOutput("auto_x_134", 32'(x_move), 134);

    mode_auto = 1'b0;
    runFrameEnd();
    checkOutput("manual_hold_x", 32'(x_move), 134);
    checkOutput("manual_hold_y", 32'(y_move), 365);
    checkOutput("manual_ready", 32'(cmd_ready), 1);

    sendCmd(D_RIGHT, 4'd5);
    checkOutput("pre_rst_full", 32'(cmd_ready), 0);
    #5;
    sys_rst_n = 1'b0;
    #3;
    checkOutput("async_rst_x", 32'(x_move), 0);
    checkOutput("async_rst_y", 32'(y_move), 0);
    checkOutput("async_rst_ready", 32'(cmd_ready), 1);
    checkOutput("async_rst_tick", 32'(frame_tick), 0);
    #40;
    sys_rst_n = 1'b1;
    stepClk();
    runFrameEnd();
    checkOutput("dropped_cmd_x", 32'(x_move), 0);
    checkOutput("dropped_cmd_y", 32'(y_move), 0);

    mode_auto = 1'b1;
    runFrameEnd();
    checkOutput("rst_auto_x", 32'(x_move), 1);
    checkOutput("rst_auto_y", 32'(y_move), 1);
    mode_auto = 1'b0;
    stepClk();

    $display("[TB] directed sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
